// File: rtl/apb_csr_pkg.sv
// Shared constants for the APB CSR front end: default widths, register map and FSM state encoding.
package apb_csr_pkg;

   localparam int APB_BUS_SIZE_DEF   = 32;
   localparam int ADDR_SIZE_DEF      = 8;
   localparam int FIFO_OUT_WIDTH_DEF = 25;

   localparam logic [7:0] CTRL_ADDR   = 8'h00;
   localparam logic [7:0] DATA0_ADDR  = 8'h04;
   localparam logic [7:0] DATA1_ADDR  = 8'h08;
   localparam logic [7:0] RESULT_ADDR = 8'h0C;
   localparam logic [7:0] STATUS_ADDR = 8'h10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_POP    = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

endpackage

// File: rtl/apb_csr_addr_dec.sv
// Combinational decode of paddr into one select per CSR register plus an unmapped flag.
module apb_csr_addr_dec
   import apb_csr_pkg::*;
#(
   parameter int ADDR_SIZE = ADDR_SIZE_DEF
)(
   input  logic [ADDR_SIZE-1:0] paddr,
   output logic                 sel_ctrl,
   output logic                 sel_data0,
   output logic                 sel_data1,
   output logic                 sel_result,
   output logic                 sel_status,
   output logic                 unmapped
);

   assign sel_ctrl   = (paddr == ADDR_SIZE'(CTRL_ADDR));
   assign sel_data0  = (paddr == ADDR_SIZE'(DATA0_ADDR));
   assign sel_data1  = (paddr == ADDR_SIZE'(DATA1_ADDR));
   assign sel_result = (paddr == ADDR_SIZE'(RESULT_ADDR));
   assign sel_status = (paddr == ADDR_SIZE'(STATUS_ADDR));

   assign unmapped = ~(sel_ctrl | sel_data0 | sel_data1 | sel_result | sel_status);

endmodule

// File: rtl/d_ff_async_en.sv
// Generic enabled register with asynchronous active-high reset to a parameterised value.
module d_ff_async_en #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Callers hand in an active-high reset; the flop itself keeps the active-low template.
   logic rst_n;
   assign rst_n = ~rst;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= RST_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/apb_csr_ctrl.sv
// APB3 slave front end for the ALU CSR unit: register write strobes, FIFO_IN push pulse, RESULT pop sequencing.
// Build option APB_CSR_PSLVERR_EN turns on pslverr for unmapped, illegal-write and empty-RESULT accesses.
module apb_csr_ctrl
   import apb_csr_pkg::*;
#(
   parameter int APB_BUS_SIZE   = APB_BUS_SIZE_DEF,
   parameter int ADDR_SIZE      = ADDR_SIZE_DEF,
   parameter int FIFO_OUT_WIDTH = FIFO_OUT_WIDTH_DEF
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      psel,
   input  logic                      penable,
   input  logic                      pwrite,
   input  logic [ADDR_SIZE-1:0]      paddr,
   output logic [APB_BUS_SIZE-1:0]   prdata,
   output logic                      pready,
   output logic                      pslverr,
   output logic                      en_ctrl,
   output logic                      en_data0,
   output logic                      en_data1,
   output logic                      w_en_in,
   output logic                      r_en_out,
   output logic                      fifo_out_rd,
   input  logic                      start_bit,
   input  logic                      fifo_in_full,
   input  logic                      fifo_out_empty,
   input  logic [FIFO_OUT_WIDTH-1:0] final_result,
   input  logic [FIFO_OUT_WIDTH-1:0] fifo_out_status,
   output logic [2:0]                state_dbg
);

   // Handshake: a transfer completes in the cycle pready is high while the master holds
   // psel/penable; prdata and pslverr carry information (and are non-zero) only in that cycle.

   logic                    rst;
   state_t                  state_q;
   state_t                  state_d;
   logic [2:0]              state_q_bits;
   logic                    w_en_d;
   logic                    sel_ctrl;
   logic                    sel_data0;
   logic                    sel_data1;
   logic                    sel_result;
   logic                    sel_status;
   logic                    unmapped;
   logic                    result_pop;
   logic                    access_err;
   logic [APB_BUS_SIZE-1:0] rd_data;

   assign rst = ~rst_n;

   apb_csr_addr_dec #(
      .ADDR_SIZE (ADDR_SIZE)
   ) u_addr_dec (
      .paddr      (paddr),
      .sel_ctrl   (sel_ctrl),
      .sel_data0  (sel_data0),
      .sel_data1  (sel_data1),
      .sel_result (sel_result),
      .sel_status (sel_status),
      .unmapped   (unmapped)
   );

   d_ff_async_en #(
      .WIDTH   (3),
      .RST_VAL (ST_IDLE)
   ) u_state_ff (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .d   (state_d),
      .q   (state_q_bits)
   );

   assign state_q   = state_t'(state_q_bits);
   assign state_dbg = state_q_bits;

   // One push per start: the pulse blocks itself, and cs_registers clears start_bit off it.
   assign w_en_d = start_bit & ~fifo_in_full & ~w_en_in;

   d_ff_async_en #(
      .WIDTH   (1),
      .RST_VAL (1'b0)
   ) u_w_en_ff (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .d   (w_en_d),
      .q   (w_en_in)
   );

   assign result_pop = ~pwrite & sel_result & ~fifo_out_empty;

   always_comb begin
      state_d     = state_q;
      pready      = 1'b0;
      en_ctrl     = 1'b0;
      en_data0    = 1'b0;
      en_data1    = 1'b0;
      fifo_out_rd = 1'b0;
      r_en_out    = 1'b0;
      access_err  = 1'b0;
      rd_data     = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (psel && !penable) begin
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_d = psel ? ST_ACCESS : ST_IDLE;
         end
         ST_ACCESS: begin
            state_d = ST_IDLE;
            if (psel) begin
               if (result_pop) begin
                  state_d = ST_POP;
               end else begin
                  pready = 1'b1;
                  // A RESULT read that reaches here found FIFO_OUT empty.
                  access_err = unmapped | (pwrite & (sel_result | sel_status)) |
                               (~pwrite & sel_result);
                  if (pwrite) begin
                     en_ctrl  = sel_ctrl;
                     en_data0 = sel_data0;
                     en_data1 = sel_data1;
                  end else if (sel_ctrl) begin
                     rd_data = APB_BUS_SIZE'(start_bit);
                  end else if (sel_status) begin
                     rd_data = APB_BUS_SIZE'(fifo_out_status);
                  end
               end
            end
         end
         ST_POP: begin
            fifo_out_rd = 1'b1;
            r_en_out    = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            r_en_out = 1'b1;
            pready   = 1'b1;
            rd_data  = APB_BUS_SIZE'(final_result);
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign prdata = access_err ? '0 : rd_data;

`ifdef APB_CSR_PSLVERR_EN
   assign pslverr = access_err;
`else
   assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_csr_ctrl.sv
// Self-checking bench for apb_csr_ctrl with a small cs_registers/FIFO environment model.
module tb_apb_csr_ctrl;
   import apb_csr_pkg::*;

`ifdef APB_CSR_PSLVERR_EN
   localparam bit PSLVERR_EN = 1'b1;
`else
   localparam bit PSLVERR_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [7:0]  paddr;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic        en_ctrl;
   logic        en_data0;
   logic        en_data1;
   logic        w_en_in;
   logic        r_en_out;
   logic        fifo_out_rd;
   logic        start_bit;
   logic        fifo_in_full;
   logic        fifo_out_empty;
   logic [24:0] final_result;
   logic [24:0] fifo_out_status;
   logic [2:0]  state_dbg;

   int checks   = 0;
   int failures = 0;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   apb_csr_ctrl u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .psel            (psel),
      .penable         (penable),
      .pwrite          (pwrite),
      .paddr           (paddr),
      .prdata          (prdata),
      .pready          (pready),
      .pslverr         (pslverr),
      .en_ctrl         (en_ctrl),
      .en_data0        (en_data0),
      .en_data1        (en_data1),
      .w_en_in         (w_en_in),
      .r_en_out        (r_en_out),
      .fifo_out_rd     (fifo_out_rd),
      .start_bit       (start_bit),
      .fifo_in_full    (fifo_in_full),
      .fifo_out_empty  (fifo_out_empty),
      .final_result    (final_result),
      .fifo_out_status (fifo_out_status),
      .state_dbg       (state_dbg)
   );

   // environment: cs_registers start bit, FIFO_OUT and RESULT register
   logic [31:0] ctrl_wdata;
   logic [24:0] fifo_mem [0:255];
   logic [7:0]  wr_ptr;
   logic [7:0]  rd_ptr = 8'd0;
   logic [24:0] result_reg;
   int          wen_total = 0;

   assign fifo_out_empty = (wr_ptr == rd_ptr);
   assign final_result   = result_reg;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) start_bit <= 1'b0;
      else if (en_ctrl && ctrl_wdata[0]) start_bit <= 1'b1;
      else if (w_en_in) start_bit <= 1'b0;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_reg <= '0;
      end else if (fifo_out_rd && (rd_ptr != wr_ptr)) begin
         result_reg <= fifo_mem[rd_ptr];
         rd_ptr     <= rd_ptr + 8'd1;
      end else if (!r_en_out) begin
         result_reg <= '0;
      end
   end

   always @(posedge clk) if (w_en_in) wen_total <= wen_total + 1;

   // scoreboard of values expected back from RESULT reads
   logic [24:0] exp_q[$];

   function automatic logic is_mapped(input logic [7:0] a);
      return (a == CTRL_ADDR) || (a == DATA0_ADDR) || (a == DATA1_ADDR) ||
             (a == RESULT_ADDR) || (a == STATUS_ADDR);
   endfunction

   function automatic logic exp_err(input logic wr, input logic [7:0] a, input logic empty);
      return PSLVERR_EN && (!is_mapped(a) || (wr && (a == RESULT_ADDR || a == STATUS_ADDR)) ||
                            (!wr && a == RESULT_ADDR && empty));
   endfunction

   // driver tasks
   task automatic push_fifo(input logic [24:0] v);
      fifo_mem[wr_ptr] = v;
      wr_ptr = wr_ptr + 8'd1;
      exp_q.push_back(v);
   endtask

   // Called #1 after a posedge; returns #1 after the posedge following completion.
   task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int cycles,
                           output int n_ctrl, output int n_d0, output int n_d1,
                           output int n_pop, output int n_ren, output int n_stray);
      logic done;
      done = 1'b0; rdata = '0; err = 1'b0; cycles = 0;
      n_ctrl = 0; n_d0 = 0; n_d1 = 0; n_pop = 0; n_ren = 0; n_stray = 0;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; ctrl_wdata = wdata;
      @(posedge clk); #1;
      penable = 1'b1;
      while (!done && cycles < 12) begin
         @(negedge clk);
         cycles++;
         n_ctrl += int'(en_ctrl);
         n_d0   += int'(en_data0);
         n_d1   += int'(en_data1);
         n_pop  += int'(fifo_out_rd);
         n_ren  += int'(r_en_out);
         if (!pready && (en_ctrl || en_data0 || en_data1 || pslverr || prdata != 32'd0)) n_stray++;
         if (pready) begin
            rdata = prdata;
            err   = pslverr;
            done  = 1'b1;
         end
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL xfer_timeout addr=%h: pready not seen in %0d cycles", addr, cycles);
      end
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
   endtask

   // tests
   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({prdata, pready, pslverr, en_ctrl, en_data0, en_data1, w_en_in, r_en_out, fifo_out_rd} !== 40'd0) begin
         failures++;
         $display("FAIL reset_outputs: got %h expected 0", {prdata, pready, pslverr, en_ctrl, en_data0,
                  en_data1, w_en_in, r_en_out, fifo_out_rd});
      end
      checks++;
      if (state_dbg !== ST_IDLE) begin
         failures++;
         $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_data_write;
      logic [31:0] rd; logic er; int cy, nc, n0, n1, np, nr, ns;
      apb_xfer(1'b1, DATA0_ADDR, 32'h1234, rd, er, cy, nc, n0, n1, np, nr, ns);
      checks++;
      if (n0 !== 1 || nc !== 0 || n1 !== 0) begin
         failures++;
         $display("FAIL data0_strobe: got ctrl=%0d d0=%0d d1=%0d expected 0/1/0", nc, n0, n1);
      end
      checks++;
      if (cy !== 2 || er !== 1'b0 || ns !== 0) begin
         failures++;
         $display("FAIL data0_resp: got cycles=%0d err=%0b stray=%0d expected 2/0/0", cy, er, ns);
      end
      apb_xfer(1'b1, DATA1_ADDR, 32'hBEEF, rd, er, cy, nc, n0, n1, np, nr, ns);
      checks++;
      if (n1 !== 1 || nc !== 0 || n0 !== 0 || cy !== 2) begin
         failures++;
         $display("FAIL data1_strobe: got ctrl=%0d d0=%0d d1=%0d cycles=%0d expected 0/0/1/2", nc, n0, n1, cy);
      end
   endtask

   task automatic test_start(input int full_cycles);
      logic [31:0] rd; logic er; int cy, nc, n0, n1, np, nr, ns;
      int s, pulse_idx, npulse, full_seen, bad;
      logic start_after;
      s = -1; pulse_idx = -1; npulse = 0; full_seen = 0; bad = 0; start_after = 1'bx;
      fifo_in_full = (full_cycles > 0);
      apb_xfer(1'b1, CTRL_ADDR, 32'h0000_0103, rd, er, cy, nc, n0, n1, np, nr, ns);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (w_en_in) begin
            npulse++;
            if (pulse_idx < 0) pulse_idx = i;
         end
         if (s >= 0 && i == s + 2) start_after = start_bit;
         if (start_bit && fifo_in_full) begin
            full_seen++;
            if (w_en_in) bad++;
            if (full_seen == full_cycles) fifo_in_full = 1'b0;
         end
         if (s < 0 && start_bit && !fifo_in_full) s = i;
      end
      checks++;
      if (npulse !== 1 || pulse_idx !== s + 1 || s < 0) begin
         failures++;
         $display("FAIL start_pulse_full%0d: got pulses=%0d at %0d expected 1 at %0d", full_cycles, npulse, pulse_idx, s + 1);
      end
      checks++;
      if (full_seen !== full_cycles || bad !== 0) begin
         failures++;
         $display("FAIL start_stall_full%0d: got stalled=%0d early_pulses=%0d expected %0d/0", full_cycles, full_seen, bad, full_cycles);
      end
      checks++;
      if (start_after !== 1'b0) begin
         failures++;
         $display("FAIL start_clear_full%0d: got start_bit=%b expected 0", full_cycles, start_after);
      end
   endtask

   task automatic test_ctrl_pending;
      logic [31:0] rd; logic er; int cy, nc, n0, n1, np, nr, ns, w0, npulse;
      fifo_in_full = 1'b1;
      w0 = wen_total;
      apb_xfer(1'b1, CTRL_ADDR, 32'h1, rd, er, cy, nc, n0, n1, np, nr, ns);
      apb_xfer(1'b1, CTRL_ADDR, 32'h1, rd, er, cy, nc, n0, n1, np, nr, ns);
      checks++;
      if (nc !== 1) begin
         failures++;
         $display("FAIL ctrl_rewrite_strobe: got %0d expected 1", nc);
      end
      apb_xfer(1'b0, CTRL_ADDR, 32'h0, rd, er, cy, nc, n0, n1, np, nr, ns);
      checks++;
      if (rd !== 32'h1 || wen_total !== w0) begin
         failures++;
         $display("FAIL ctrl_pending_read: got prdata=%h pushes=%0d expected 1/0", rd, wen_total - w0);
      end
      fifo_in_full = 1'b0;
      npulse = 0;
      repeat (6) begin
         @(negedge clk);
         if (w_en_in) npulse++;
      end
      checks++;
      if (npulse !== 1 || start_bit !== 1'b0) begin
         failures++;
         $display("FAIL ctrl_pending_push: got pulses=%0d start=%b expected 1/0", npulse, start_bit);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_result_pop;
      logic [31:0] rd; logic er; int cy, nc, n0, n1, np, nr, ns;
      logic [24:0] e;
      push_fifo(25'h1ABCDEF);
      e = exp_q.pop_front();
      apb_xfer(1'b0, RESULT_ADDR, 32'h0, rd, er, cy, nc, n0, n1, np, nr, ns);
      checks++;
      if (rd !== {7'd0, e} || er !== 1'b0) begin
         failures++;
         $display("FAIL result_data: got %h err=%b expected %h err=0", rd, er, {7'd0, e});
      end
      checks++;
      if (cy !== 4 || np !== 1 || nr !== 2 || ns !== 0) begin
         failures++;
         $display("FAIL result_seq: got cycles=%0d pops=%0d ren=%0d stray=%0d expected 4/1/2/0", cy, np, nr, ns);
      end
      checks++;
      if (r_en_out !== 1'b0) begin
         failures++;
         $display("FAIL result_ren_drop: got %b expected 0", r_en_out);
      end
   endtask

   task automatic test_result_empty;
      logic [31:0] rd; logic er; int cy, nc, n0, n1, np, nr, ns;
      apb_xfer(1'b0, RESULT_ADDR, 32'h0, rd, er, cy, nc, n0, n1, np, nr, ns);
      checks++;
      if (cy !== 2 || rd !== 32'd0 || np !== 0 || er !== exp_err(1'b0, RESULT_ADDR, 1'b1)) begin
         failures++;
         $display("FAIL result_empty: got cycles=%0d data=%h pops=%0d err=%b expected 2/0/0/%b",
                  cy, rd, np, er, exp_err(1'b0, RESULT_ADDR, 1'b1));
      end
   endtask

   task automatic test_errors;
      logic [31:0] rd; logic er; int cy, nc, n0, n1, np, nr, ns;
      logic       wr_t [4];
      logic [7:0] ad_t [4];
      wr_t = '{1'b1, 1'b1, 1'b0, 1'b1};
      ad_t = '{RESULT_ADDR, STATUS_ADDR, 8'h14, 8'hFF};
      for (int i = 0; i < 4; i++) begin
         apb_xfer(wr_t[i], ad_t[i], 32'hFFFF_FFFE, rd, er, cy, nc, n0, n1, np, nr, ns);
         checks++;
         if (cy !== 2 || rd !== 32'd0 || (nc + n0 + n1 + np) !== 0 || er !== exp_err(wr_t[i], ad_t[i], fifo_out_empty)) begin
            failures++;
            $display("FAIL err_access%0d: got cycles=%0d data=%h strobes=%0d err=%b expected 2/0/0/%b",
                     i, cy, rd, nc + n0 + n1 + np, er, exp_err(wr_t[i], ad_t[i], fifo_out_empty));
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] rd; logic er; int cy, nc, n0, n1, np, nr, ns;
      logic [24:0] e;
      push_fifo(25'h0000001);
      push_fifo(25'h1FFFFFF);
      fifo_out_status = 25'h0155AA3;
      for (int i = 0; i < 2; i++) begin
         e = exp_q.pop_front();
         apb_xfer(1'b0, RESULT_ADDR, 32'h0, rd, er, cy, nc, n0, n1, np, nr, ns);
         checks++;
         if (rd !== {7'd0, e} || cy !== 4 || np !== 1) begin
            failures++;
            $display("FAIL b2b_result%0d: got %h cycles=%0d pops=%0d expected %h/4/1", i, rd, cy, np, {7'd0, e});
         end
      end
      apb_xfer(1'b0, STATUS_ADDR, 32'h0, rd, er, cy, nc, n0, n1, np, nr, ns);
      checks++;
      if (rd !== 32'h0155AA3 || cy !== 2) begin
         failures++;
         $display("FAIL b2b_status: got %h cycles=%0d expected 00155aa3/2", rd, cy);
      end
   endtask

   task automatic test_reset_in_pop;
      logic [31:0] rd; logic er; int cy, nc, n0, n1, np, nr, ns;
      logic seen;
      logic [24:0] e;
      push_fifo(25'h0A5A5A5);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = RESULT_ADDR;
      @(posedge clk); #1;
      penable = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         if (fifo_out_rd) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL rst_pop_reach: got no fifo_out_rd expected one");
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({prdata, pready, pslverr, en_ctrl, en_data0, en_data1, w_en_in, r_en_out, fifo_out_rd} !== 40'd0 ||
          state_dbg !== ST_IDLE) begin
         failures++;
         $display("FAIL rst_in_pop: got outputs=%h state=%0d expected 0/%0d", {prdata, pready, pslverr, en_ctrl,
                  en_data0, en_data1, w_en_in, r_en_out, fifo_out_rd}, state_dbg, ST_IDLE);
      end
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      apb_xfer(1'b0, RESULT_ADDR, 32'h0, rd, er, cy, nc, n0, n1, np, nr, ns);
      checks++;
      if (rd !== {7'd0, e} || cy !== 4 || np !== 1) begin
         failures++;
         $display("FAIL rst_recover: got %h cycles=%0d pops=%0d expected %h/4/1", rd, cy, np, {7'd0, e});
      end
   endtask

   task automatic test_random(input int n);
      logic [31:0] rd, exp_rd; logic er, wr, empty, pop; int cy, nc, n0, n1, np, nr, ns, w0;
      logic [7:0] a;
      w0 = wen_total;
      for (int it = 0; it < n; it++) begin
         if ($urandom_range(0, 2) == 0) push_fifo(25'($urandom));
         fifo_out_status = 25'($urandom);
         wr = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: a = CTRL_ADDR;
            1: a = DATA0_ADDR;
            2: a = DATA1_ADDR;
            3: a = RESULT_ADDR;
            4: a = STATUS_ADDR;
            default: begin
               a = 8'($urandom_range(0, 255));
               while (is_mapped(a)) a = 8'($urandom_range(0, 255));
            end
         endcase
         empty  = (exp_q.size() == 0);
         pop    = !wr && a == RESULT_ADDR && !empty;
         exp_rd = '0;
         if (!wr && a == STATUS_ADDR) exp_rd = {7'd0, fifo_out_status};
         if (pop) exp_rd = {7'd0, exp_q.pop_front()};
         apb_xfer(wr, a, $urandom & 32'hFFFF_FFFE, rd, er, cy, nc, n0, n1, np, nr, ns);
         checks++;
         if (rd !== exp_rd || cy !== (pop ? 4 : 2)) begin
            failures++;
            $display("FAIL rand%0d_data wr=%b addr=%h: got %h cycles=%0d expected %h/%0d", it, wr, a, rd, cy, exp_rd, pop ? 4 : 2);
         end
         checks++;
         if (er !== exp_err(wr, a, empty)) begin
            failures++;
            $display("FAIL rand%0d_err wr=%b addr=%h: got %b expected %b", it, wr, a, er, exp_err(wr, a, empty));
         end
         checks++;
         if (nc !== int'(wr && a == CTRL_ADDR) || n0 !== int'(wr && a == DATA0_ADDR) ||
             n1 !== int'(wr && a == DATA1_ADDR) || np !== int'(pop) || nr !== (pop ? 2 : 0) || ns !== 0) begin
            failures++;
            $display("FAIL rand%0d_strobes wr=%b addr=%h: got c/d0/d1/pop/ren/stray=%0d/%0d/%0d/%0d/%0d/%0d",
                     it, wr, a, nc, n0, n1, np, nr, ns);
         end
      end
      checks++;
      if (wen_total !== w0) begin
         failures++;
         $display("FAIL rand_no_push: got %0d pushes expected 0", wen_total - w0);
      end
   endtask

   initial begin
      rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
      fifo_in_full = 1'b0; fifo_out_status = '0; ctrl_wdata = '0; wr_ptr = '0;
      test_reset();
      test_data_write();
      test_start(0);
      test_start(5);
      test_ctrl_pending();
      test_result_pop();
      test_result_empty();
      test_errors();
      test_back_to_back();
      test_reset_in_pop();
      test_random(40);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
